// File: rtl/swdb_pkg.sv
// Shared types and defaults for the switch debouncer.
package swdb_pkg;
  localparam int SWDB_WIDTH         = 16;
  localparam int SWDB_DEBOUNCE_10MS = 1_000_000;

  typedef logic [SWDB_WIDTH-1:0] sw_vec_t;
endpackage

// File: rtl/debounce_timer.sv
// Shared stability counter: clears on any input change, counts up and saturates at CYCLES-1.
module debounce_timer #(
  parameter int CYCLES = 4,
  parameter int CNT_W  = (CYCLES > 2) ? $clog2(CYCLES) : 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic sat
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  assign sat = (r_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (!reset_n)       r_cnt <= '0;
    else if (clr)       r_cnt <= '0;
    else if (en && !sat) r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/switch_debouncer.sv
// Whole-vector switch debouncer with a coalescing valid/ready change event.
// Optional interrupt output enabled by defining SWITCH_DEBOUNCE_IRQ_EN.
module switch_debouncer
  import swdb_pkg::*;
#(
  parameter int WIDTH           = SWDB_WIDTH,
  parameter int DEBOUNCE_CYCLES = SWDB_DEBOUNCE_10MS
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sync_value,
  output logic [WIDTH-1:0] stable_value,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_changed
`ifdef SWITCH_DEBOUNCE_IRQ_EN
  ,
  output logic             irq,
  input  logic [WIDTH-1:0] irq_mask
`endif
);
  generate
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
      $error("switch_debouncer: DEBOUNCE_CYCLES must be >= 2");
    end
  endgenerate

  logic [WIDTH-1:0] r_cand;
  logic [WIDTH-1:0] r_stable;
  logic             r_evt_valid;
  logic [WIDTH-1:0] r_evt_changed;

  logic             w_clr;
  logic             w_sat;
  logic             w_commit;
  logic             w_xfer;
  logic [WIDTH-1:0] w_diff;

  assign w_clr    = (sync_value != r_cand);
  assign w_commit = !w_clr && w_sat && (r_cand != r_stable);
  assign w_diff   = r_cand ^ r_stable;
  assign w_xfer   = r_evt_valid && evt_ready;

  debounce_timer #(.CYCLES(DEBOUNCE_CYCLES)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (w_clr),
    .en      (!w_clr),
    .sat     (w_sat)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cand        <= '0;
      r_stable      <= '0;
      r_evt_valid   <= 1'b0;
      r_evt_changed <= '0;
    end else begin
      if (w_clr) r_cand <= sync_value;
      if (w_commit) begin
        r_stable    <= r_cand;
        r_evt_valid <= 1'b1;
        // A commit landing on a transfer starts a fresh event; otherwise pending bits are kept.
        if (!r_evt_valid || w_xfer) r_evt_changed <= w_diff;
        else                        r_evt_changed <= r_evt_changed | w_diff;
      end else if (w_xfer) begin
        r_evt_valid   <= 1'b0;
        r_evt_changed <= '0;
      end
    end
  end

  assign stable_value = r_stable;
  assign evt_valid    = r_evt_valid;
  assign evt_changed  = r_evt_changed;

`ifdef SWITCH_DEBOUNCE_IRQ_EN
  logic r_irq;

  always_ff @(posedge clk) begin
    if (!reset_n) r_irq <= 1'b0;
    else          r_irq <= r_evt_valid && |(r_evt_changed & irq_mask);
  end

  assign irq = r_irq;
`endif
endmodule

// File: tb/tb_switch_debouncer.sv
// Directed + randomized bench for switch_debouncer (DEBOUNCE_CYCLES=4) against a run-length model.
module tb_switch_debouncer;
  localparam int W  = 16;
  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] sync_value = '0;
  logic [W-1:0] stable_value;
  logic         evt_valid;
  logic         evt_ready = 1'b0;
  logic [W-1:0] evt_changed;
`ifdef SWITCH_DEBOUNCE_IRQ_EN
  logic         irq;
  logic [W-1:0] irq_mask = 16'h8000;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: a value commits once it has been sampled DC+1 edges in a row.
  logic [W-1:0] m_last, m_stable, m_chg;
  logic         m_valid, m_irq;
  int           m_run;

  always #5 clk = ~clk;

  switch_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sync_value   (sync_value),
    .stable_value (stable_value),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_changed  (evt_changed)
`ifdef SWITCH_DEBOUNCE_IRQ_EN
    ,
    .irq          (irq),
    .irq_mask     (irq_mask)
`endif
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input logic rst, input logic [W-1:0] v, input logic rdy
`ifdef SWITCH_DEBOUNCE_IRQ_EN
                            , input logic [W-1:0] mask
`endif
                           );
    logic commit, xfer;
    logic [W-1:0] diff;
    if (!rst) begin
      m_last = '0; m_run = 1; m_stable = '0; m_valid = 1'b0; m_chg = '0; m_irq = 1'b0;
    end else begin
`ifdef SWITCH_DEBOUNCE_IRQ_EN
      m_irq = m_valid && ((m_chg & mask) != '0);
`endif
      if (v == m_last) m_run = (m_run < 1000) ? m_run + 1 : m_run;
      else begin m_last = v; m_run = 1; end
      commit = (m_run >= DC + 1) && (m_last != m_stable);
      diff   = m_last ^ m_stable;
      xfer   = m_valid && rdy;
      if (commit) begin
        m_chg    = (!m_valid || xfer) ? diff : (m_chg | diff);
        m_valid  = 1'b1;
        m_stable = m_last;
      end else if (xfer) begin
        m_valid = 1'b0; m_chg = '0;
      end
    end
  endtask

  // Drive one cycle, advance the model on the edge, then compare just after it.
  task automatic step(input logic [W-1:0] v, input logic rdy, input logic rst);
    sync_value = v; evt_ready = rdy; reset_n = rst;
    @(posedge clk);
`ifdef SWITCH_DEBOUNCE_IRQ_EN
    model_edge(rst, v, rdy, irq_mask);
`else
    model_edge(rst, v, rdy);
`endif
    #1;
    chk("model_stable", stable_value, m_stable);
    chk("model_valid", {15'd0, evt_valid}, {15'd0, m_valid});
    chk("model_changed", evt_changed, m_chg);
`ifdef SWITCH_DEBOUNCE_IRQ_EN
    chk("model_irq", {15'd0, irq}, {15'd0, m_irq});
`endif
  endtask

  initial begin
    m_last = '0; m_stable = '0; m_chg = '0; m_valid = 1'b0; m_irq = 1'b0; m_run = 1;

    // 1 reset with all switches high
    repeat (3) step(16'hFFFF, 1'b0, 1'b0);
    chk("rst_stable", stable_value, 16'h0000);
    chk("rst_valid", {15'd0, evt_valid}, 16'h0000);
    chk("rst_changed", evt_changed, 16'h0000);

    // 2 step to bit 0, commit exactly on edge 5
    for (int i = 1; i <= 4; i++) step(16'h0001, 1'b0, 1'b1);
    chk("step_edge4", stable_value, 16'h0000);
    step(16'h0001, 1'b0, 1'b1);
    chk("step_edge5", stable_value, 16'h0001);
    chk("step_valid", {15'd0, evt_valid}, 16'h0001);
    chk("step_changed", evt_changed, 16'h0001);
    step(16'h0001, 1'b0, 1'b1);
`ifdef SWITCH_DEBOUNCE_IRQ_EN
    chk("irq_masked_off", {15'd0, irq}, 16'h0000);
`endif

    // 3 glitch shorter than the window
    repeat (3) step(16'h0002, 1'b0, 1'b1);
    repeat (8) step(16'h0001, 1'b0, 1'b1);
    chk("glitch_stable", stable_value, 16'h0001);
    chk("glitch_changed", evt_changed, 16'h0001);

    // 4 coalesce two further events, then accept
    repeat (6) step(16'h0011, 1'b0, 1'b1);
    repeat (6) step(16'h0111, 1'b0, 1'b1);
    chk("coal_stable", stable_value, 16'h0111);
    chk("coal_valid", {15'd0, evt_valid}, 16'h0001);
    chk("coal_changed", evt_changed, 16'h0111);
    step(16'h0111, 1'b1, 1'b1);
    chk("accept_valid", {15'd0, evt_valid}, 16'h0000);
    chk("accept_changed", evt_changed, 16'h0000);

    // 5 pending event, then accept on the same edge bit 15 commits
    repeat (6) step(16'h0110, 1'b0, 1'b1);
    chk("pre_coll_changed", evt_changed, 16'h0001);
    repeat (4) step(16'h8110, 1'b0, 1'b1);
    chk("coll_edge4", stable_value, 16'h0110);
    step(16'h8110, 1'b1, 1'b1);
    chk("coll_stable", stable_value, 16'h8110);
    chk("coll_valid", {15'd0, evt_valid}, 16'h0001);
    chk("coll_changed", evt_changed, 16'h8000);
    step(16'h8110, 1'b0, 1'b1);
`ifdef SWITCH_DEBOUNCE_IRQ_EN
    chk("irq_bit15", {15'd0, irq}, 16'h0001);
`endif

    // 6 reset part-way through a count, then a full re-debounce
    repeat (3) step(16'h00F0, 1'b0, 1'b1);
    step(16'h00F0, 1'b0, 1'b0);
    chk("midrst_stable", stable_value, 16'h0000);
    chk("midrst_valid", {15'd0, evt_valid}, 16'h0000);
    for (int i = 1; i <= 4; i++) step(16'h00F0, 1'b0, 1'b1);
    chk("redeb_edge4", stable_value, 16'h0000);
    step(16'h00F0, 1'b0, 1'b1);
    chk("redeb_edge5", stable_value, 16'h00F0);
    chk("redeb_changed", evt_changed, 16'h00F0);

    // randomized bouncing with random accepts and rare resets
    for (int n = 0; n < 400; n++) begin
      logic [W-1:0] v;
      int hold;
      v    = W'($urandom_range(0, 7)) << $urandom_range(0, 13);
      hold = $urandom_range(1, 8);
`ifdef SWITCH_DEBOUNCE_IRQ_EN
      if ($urandom_range(0, 15) == 0) irq_mask = W'($urandom);
`endif
      for (int h = 0; h < hold; h++)
        step(v, ($urandom_range(0, 3) == 0), ($urandom_range(0, 199) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
